// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions and FSM state encoding.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_OVF_CLR = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output and
// occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core data port:
// register decode, TX FIFO and bit-timing FSM.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    uart_tx_state_e state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] div_q, div_d;
    logic [15:0] divisor_q, divisor_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;

    logic [1:0]  off;
    logic        wr, push, pop, bit_end;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    logic [31:0] status;
    logic        addr_unused;

    assign addr_unused = ^{addr[1:0], wd[31:16]};

    assign off  = addr[3:2];
    assign hit  = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr   = we && hit;
    assign push = wr && (off == REG_TXDATA);
    assign tx   = tx_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                  = '0;
        status[ST_BUSY]         = (state_q != IDLE);
        status[ST_FULL]         = fifo_full;
        status[ST_EMPTY]        = fifo_empty;
        status[ST_OVF]          = ovf_q;
        status[ST_CNT_LSB +: 8] = 8'(fifo_count);
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (off)
                REG_STATUS: rd = status;
                REG_DIV:    rd = {16'h0, divisor_q};
                REG_CTRL:   rd = {31'h0, en_q};
                default:    rd = '0;
            endcase
        end
    end

    // A dropped push sets overflow even when a clear lands on the same edge.
    always_comb begin
        divisor_d = divisor_q;
        en_d      = en_q;
        ovf_d     = ovf_q;
        if (wr && off == REG_DIV) divisor_d = wd[15:0];
        if (wr && off == REG_CTRL) begin
            en_d = wd[CTRL_EN];
            if (wd[CTRL_OVF_CLR]) ovf_d = 1'b0;
        end
        if (push && fifo_full) ovf_d = 1'b1;
    end

    assign bit_end = (timer_q == div_q - 16'd1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    div_d   = (divisor_q == '0) ? 16'd1 : divisor_q;
                    bit_d   = '0;
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    timer_d = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            div_q     <= 16'd1;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            divisor_q <= DEFAULT_DIV;
            en_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            divisor_q <= divisor_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
